// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the ID stage, the pipeline controller and the
// hazard scoreboard. The master is the pipeline (decode fields, flush, memory
// ready); the slave is the scoreboard (stall request, forwarding selects).
interface hazard_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_write;
    logic        id_is_load;
    logic        flush;
    logic        mem_ready;
    logic        want_stall;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic [31:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_write, id_is_load, flush, mem_ready,
        input  want_stall, fwd_rs1_sel, fwd_rs2_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_write, id_is_load, flush, mem_ready,
        output want_stall, fwd_rs1_sel, fwd_rs2_sel, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes from EX (slot 0) to WB
// (slot DEPTH-1), requests decode stalls on load-use hazards (or on every RAW
// hazard when forwarding is disabled), freezes on data-memory busy and picks
// operand forwarding sources for EX.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,   // 2..3 in-flight slots
    parameter int FWD_ENABLE = 1,
    parameter int RF_BYPASS  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    hazard_scoreboard_if.slave io_sb
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_load;
    logic [4:0]       r_rd [DEPTH];
    logic [31:0]      r_stall_count;

    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_stall;
    logic             w_insert;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2;

    // A source only hazards against the WB slot when the regfile cannot bypass
    // a same-cycle write; with forwarding, only a load sitting in EX hazards.
    function automatic logic f_hazard(input logic [DEPTH-1:0] m, input logic load0);
        logic h;
        h = 1'b0;
        if (FWD_ENABLE != 0)
            h = m[0] && load0;
        else
            h = |m[DEPTH-2:0];
        if (RF_BYPASS == 0)
            h = h || m[DEPTH-1];
        return h;
    endfunction

    // Youngest producer wins; a load still in EX has no result to forward.
    function automatic logic [1:0] f_sel(input logic [DEPTH-1:0] m, input logic load0,
                                         input logic haz);
        logic [1:0] s;
        s = 2'd0;
        if (FWD_ENABLE != 0 && !haz) begin
            if (m[0])
                s = load0 ? 2'd0 : 2'd1;
            else if (DEPTH == 3 && m[1])
                s = 2'd2;
        end
        return s;
    endfunction

    // Per-slot source match; x0 and unused operands never match.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match1[gi] = r_valid[gi] && (r_rd[gi] == io_sb.id_rs1) &&
                                  (io_sb.id_rs1 != 5'd0) && io_sb.id_rs1_used;
            assign w_match2[gi] = r_valid[gi] && (r_rd[gi] == io_sb.id_rs2) &&
                                  (io_sb.id_rs2 != 5'd0) && io_sb.id_rs2_used;
        end
    endgenerate

    assign w_haz1   = io_sb.id_valid && f_hazard(w_match1, r_load[0]);
    assign w_haz2   = io_sb.id_valid && f_hazard(w_match2, r_load[0]);
    assign w_stall  = !io_sb.mem_ready || w_haz1 || w_haz2;
    assign w_sel1   = f_sel(w_match1, r_load[0], w_haz1);
    assign w_sel2   = f_sel(w_match2, r_load[0], w_haz2);

    // Only real, non-killed, non-stalled writers to a non-zero register are tracked.
    assign w_insert = io_sb.id_valid && io_sb.id_rd_write && (io_sb.id_rd != 5'd0) &&
                      !io_sb.flush && !w_stall;

    // Outputs are held quiet while reset is asserted.
    assign io_sb.want_stall  = !i_rst && w_stall;
    assign io_sb.fwd_rs1_sel = i_rst ? 2'd0 : w_sel1;
    assign io_sb.fwd_rs2_sel = i_rst ? 2'd0 : w_sel2;
    assign io_sb.stall_count = r_stall_count;

    // Slot pipeline advance/freeze and saturating stall-cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid       <= '0;
            r_load        <= '0;
            r_stall_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_rd[i] <= 5'd0;
        end else begin
            if (w_stall && r_stall_count != '1)
                r_stall_count <= r_stall_count + 32'd1;
            if (io_sb.mem_ready) begin
                for (int i = 1; i < DEPTH; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    r_load[i]  <= r_load[i-1];
                    r_rd[i]    <= r_rd[i-1];
                end
                r_valid[0] <= w_insert;
                r_load[0]  <= w_insert && io_sb.id_is_load;
                r_rd[0]    <= io_sb.id_rd;
            end
        end
    end

endmodule
